// File: rtl/board_io_pkg.sv
// Shared constants for the board I/O conditioning logic on the 12 MHz CMOD A7 sysclk.
package board_io_pkg;

  localparam int DEBOUNCE_CYCLES_1MS_12MHZ = 12000;
  localparam int RST_STRETCH_DEFAULT       = 16;
  // Smallest counter width that can hold DEBOUNCE_CYCLES_1MS_12MHZ-1.
  localparam int DEBOUNCE_CNT_W            = $clog2(DEBOUNCE_CYCLES_1MS_12MHZ);

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-flop synchronizer, stability counter, and registered
// rise/fall pulses that coincide with the first cycle of a new debounced level.
module btn_debounce_chan
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_1MS_12MHZ,
  parameter int CNT_W           = DEBOUNCE_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Metastability chain; s1 feeds s2 directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw_i;
      s2 <= s1;
    end
  end

  // Any return to the accepted level restarts the count, which rejects short glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= CNT_ZERO;
      level_o <= 1'b0;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (s2 == level_o) begin
        cnt <= CNT_ZERO;
      end else if (cnt == CNT_LAST) begin
        cnt     <= CNT_ZERO;
        level_o <= s2;
        rise_o  <= s2;
        fall_o  <= ~s2;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/board_btn_conditioner.sv
// Button conditioning upstream of the core: debounced levels/edges per button and a
// stretched, synchronously released active-low core reset driven by one button.
module board_btn_conditioner
  import board_io_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_1MS_12MHZ,
  parameter int CNT_W           = DEBOUNCE_CNT_W,
  parameter int RST_BTN_IDX     = 0,
  parameter int RST_STRETCH     = RST_STRETCH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_i,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic [NUM_BTN-1:0] btn_rise_o,
  output logic [NUM_BTN-1:0] btn_fall_o,
  output logic               sys_rst_n_o
);

  localparam logic [7:0] STRETCH_LOAD = 8'(RST_STRETCH);
  localparam logic [7:0] STRETCH_ZERO = 8'd0;
  localparam logic [7:0] STRETCH_ONE  = 8'd1;

  logic [7:0] stretch_cnt;
  logic       rst_btn_level;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (btn_i[i]),
      .level_o (btn_level_o[i]),
      .rise_o  (btn_rise_o[i]),
      .fall_o  (btn_fall_o[i])
    );
  end

  assign rst_btn_level = btn_level_o[RST_BTN_IDX];

  // Reset is asserted asynchronously by rst but only ever released on a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stretch_cnt <= STRETCH_LOAD;
      sys_rst_n_o <= 1'b0;
    end else begin
      if (rst_btn_level) begin
        stretch_cnt <= STRETCH_LOAD;
      end else if (stretch_cnt != STRETCH_ZERO) begin
        stretch_cnt <= stretch_cnt - STRETCH_ONE;
      end else begin
        stretch_cnt <= STRETCH_ZERO;
      end
      sys_rst_n_o <= (stretch_cnt == STRETCH_ZERO) && !rst_btn_level;
    end
  end

endmodule

// File: tb/tb_board_btn_conditioner.sv
// Directed scoreboard bench for board_btn_conditioner (DEBOUNCE_CYCLES=8, CNT_W=3).
module tb_board_btn_conditioner;

  typedef struct packed {
    logic [7:0] edges;
    logic       sel;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;
    logic       rstn;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] btn = 2'b00;
  logic [1:0] btn2 = 2'b00;
  logic [1:0] lvl, rise, fall, lvl2, rise2, fall2;
  logic       rstn, rstn2;

  exp_t  sb[$];
  string tag_q[$];
  int    tests = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  board_btn_conditioner #(
    .NUM_BTN(2), .DEBOUNCE_CYCLES(8), .CNT_W(3), .RST_BTN_IDX(0), .RST_STRETCH(4)
  ) u_dut (
    .clk(clk), .rst(rst), .btn_i(btn), .btn_level_o(lvl),
    .btn_rise_o(rise), .btn_fall_o(fall), .sys_rst_n_o(rstn)
  );

  // Second instance with a longer stretch so a re-press can land inside the stretch window.
  board_btn_conditioner #(
    .NUM_BTN(2), .DEBOUNCE_CYCLES(8), .CNT_W(3), .RST_BTN_IDX(0), .RST_STRETCH(16)
  ) u_dut2 (
    .clk(clk), .rst(rst), .btn_i(btn2), .btn_level_o(lvl2),
    .btn_rise_o(rise2), .btn_fall_o(fall2), .sys_rst_n_o(rstn2)
  );

  task automatic push(input string tag, input int edges, input logic sel,
                      input logic [1:0] e_lvl, input logic [1:0] e_rise,
                      input logic [1:0] e_fall, input logic e_rstn);
    exp_t e;
    e.edges = 8'(edges);
    e.sel   = sel;
    e.lvl   = e_lvl;
    e.rise  = e_rise;
    e.fall  = e_fall;
    e.rstn  = e_rstn;
    sb.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check(input string tag, input string what,
                       input logic [1:0] obs, input logic [1:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s.%s observed=%b expected=%b", tag, what, obs, exp_v);
    end
  endtask

  task automatic drain();
    exp_t       e;
    string      t;
    logic [1:0] o_lvl, o_rise, o_fall;
    logic       o_rstn;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      t = tag_q.pop_front();
      repeat (int'(e.edges)) @(posedge clk);
      #1;
      if (e.sel == 1'b0) begin
        o_lvl = lvl;  o_rise = rise;  o_fall = fall;  o_rstn = rstn;
      end else begin
        o_lvl = lvl2; o_rise = rise2; o_fall = fall2; o_rstn = rstn2;
      end
      check(t, "level", o_lvl, e.lvl);
      check(t, "rise", o_rise, e.rise);
      check(t, "fall", o_fall, e.fall);
      check(t, "rst_n", {1'b0, o_rstn}, {1'b0, e.rstn});
    end
  endtask

  initial begin
    // Power-on reset: async assertion, then stretch of 4 -> release on edge 5.
    #2 rst = 1'b1;
    push("por_async", 0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    drain();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    push("por_stretch", 4, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    push("por_release", 1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
    push("por_idle",    3, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
    drain();

    // Clean press/release on button 1: visible after exactly 10 edges.
    btn = 2'b10;
    push("press_wait", 9, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
    push("press_rise", 1, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1);
    push("press_end",  1, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1);
    drain();
    btn = 2'b00;
    push("rel_wait", 9, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1);
    push("rel_fall", 1, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1);
    push("rel_end",  1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
    drain();

    // Bounce: 7 high, 1 low, 7 high, low -> never accepted.
    btn = 2'b10;
    for (int i = 0; i < 7; i++) begin push("bounce_h1", 1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1); drain(); end
    btn = 2'b00;
    push("bounce_l1", 1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
    drain();
    btn = 2'b10;
    for (int i = 0; i < 7; i++) begin push("bounce_h2", 1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1); drain(); end
    btn = 2'b00;
    for (int i = 0; i < 4; i++) begin push("bounce_l2", 1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1); drain(); end
    btn = 2'b10;
    push("bhold_wait", 9, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
    push("bhold_rise", 1, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1);
    drain();
    btn = 2'b00;
    push("bhold_relw", 9, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1);
    push("bhold_fall", 1, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1);
    drain();

    // Reset button held 20 cycles, then released: stretch of 4 after the fall.
    btn = 2'b01;
    push("rb_wait",  9, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
    push("rb_rise",  1, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1);
    push("rb_low",   1, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
    push("rb_hold",  9, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
    drain();
    btn = 2'b00;
    push("rb_relw",    9, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
    push("rb_fall",    1, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0);
    push("rb_stretch", 4, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    push("rb_rstn",    1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
    drain();

    // Re-press during stretch (stretch 16); earliest possible re-acceptance is 8 edges after the fall.
    btn2 = 2'b01;
    push("rp_wait", 9, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1);
    push("rp_rise", 1, 1'b1, 2'b01, 2'b01, 2'b00, 1'b1);
    push("rp_low",  1, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
    push("rp_hold", 2, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
    drain();
    btn2 = 2'b00;
    push("rp_relw", 8, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
    drain();
    btn2 = 2'b01;
    push("rp_prefall", 1, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
    push("rp_fall",    1, 1'b1, 2'b00, 2'b00, 2'b01, 1'b0);
    for (int i = 0; i < 7; i++) push("rp_stretch", 1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
    push("rp_repress", 1, 1'b1, 2'b01, 2'b01, 2'b00, 1'b0);
    push("rp_held",    3, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
    drain();
    btn2 = 2'b00;
    push("rp2_relw",    9, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
    push("rp2_fall",    1, 1'b1, 2'b00, 2'b00, 2'b01, 1'b0);
    push("rp2_stretch", 16, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
    push("rp2_rstn",    1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1);
    drain();

    // Async rst mid-debounce: partial count is discarded.
    btn = 2'b10;
    push("r6_pre", 5, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
    drain();
    rst = 1'b1;
    push("r6_clear",  0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    push("r6_clear2", 0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
    push("r6_hold",   1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    drain();
    rst = 1'b0;
    push("r6_w",      4, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    push("r6_rstn",   1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
    push("r6_w2",     4, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
    push("r6_accept", 1, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1);
    push("r6_after",  1, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
